// File: rtl/fdiv_pkg.sv
// Shared defaults and error codes for the programmable frequency divider.
// fdiv_prog also supports the FDIV_PROG_DUTY50_EN build option.
package fdiv_pkg;

    localparam int FDIV_W_DEF       = 4;
    localparam int FDIV_DIV_RST_DEF = 5;

    // A load request with a zero divisor is the only error the block reports.
    typedef enum logic {
        FDIV_ERR_NONE     = 1'b0,
        FDIV_ERR_DIV_ZERO = 1'b1
    } fdiv_err_e;

    localparam fdiv_err_e FDIV_ERR_CODE_DIV_ZERO = FDIV_ERR_DIV_ZERO;

endpackage

// File: rtl/fdiv_cnt.sv
// Wrapping up-counter: 0..i_last, with synchronous reset, clear and enable.
// o_tc flags the terminal value, where the next enabled step wraps to zero.
module fdiv_cnt #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;
    logic         w_tc;

    // Using >= keeps the counter in range even if i_last ever drops below it.
    assign w_tc = (r_cnt >= i_last);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (w_tc) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + W'(1);
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = w_tc;

endmodule

// File: rtl/fdiv_prog.sv
// Programmable divider: active divisor plus shadow register that takes effect at wrap or clear.
// FDIV_PROG_DUTY50_EN selects a registered ~50% duty output instead of the cnt==0 pulse.
module fdiv_prog
    import fdiv_pkg::*;
#(
    parameter int W       = FDIV_W_DEF,
    parameter int DIV_RST = FDIV_DIV_RST_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         c_up,
    input  logic         div_ld,
    input  logic [W-1:0] div_val,
    output logic         fdclk,
    output logic [W-1:0] cnt,
    output logic         div_pend,
    output logic         div_err
);

    localparam logic [W-1:0] DIV_RST_V = W'(DIV_RST);

    logic [W-1:0] r_div_act;
    logic [W-1:0] r_div_nxt;
    logic         r_div_pend;
    fdiv_err_e    r_err;

    logic [W-1:0] w_cnt;
    logic [W-1:0] w_last;
    logic         w_tc;
    logic         w_xfer;
    logic         w_ld_ok;
    logic         w_ld_bad;

    assign w_last   = r_div_act - W'(1);
    assign w_ld_ok  = div_ld && (div_val != '0);
    assign w_ld_bad = div_ld && (div_val == '0);
    // Shadow moves into the active divisor only where the count restarts at zero.
    assign w_xfer   = r_div_pend && (clr || (c_up && w_tc));

    fdiv_cnt #(
        .W(W)
    ) u_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (clr),
        .i_en  (c_up),
        .i_last(w_last),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_act  <= DIV_RST_V;
            r_div_nxt  <= DIV_RST_V;
            r_div_pend <= 1'b0;
            r_err      <= FDIV_ERR_NONE;
        end else begin
            r_err <= w_ld_bad ? FDIV_ERR_CODE_DIV_ZERO : FDIV_ERR_NONE;
            if (w_xfer) begin
                r_div_act <= r_div_nxt;
            end
            // A fresh load in the transfer cycle re-arms the shadow with the new value.
            if (w_ld_ok) begin
                r_div_nxt  <= div_val;
                r_div_pend <= 1'b1;
            end else if (w_xfer) begin
                r_div_pend <= 1'b0;
            end
        end
    end

`ifdef FDIV_PROG_DUTY50_EN
    logic         r_fdclk;
    logic [W-1:0] w_half;

    assign w_half = r_div_act >> 1;

    // High while cnt is 1..div_act/2; divide-by-one simply holds the output high.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_fdclk <= 1'b0;
        end else if (r_div_act == W'(1)) begin
            r_fdclk <= 1'b1;
        end else if (c_up) begin
            if (w_cnt == '0) begin
                r_fdclk <= 1'b1;
            end else if (w_cnt == w_half) begin
                r_fdclk <= 1'b0;
            end
        end
    end

    assign fdclk = r_fdclk;
`else
    assign fdclk = (w_cnt == '0);
`endif

    assign cnt      = w_cnt;
    assign div_pend = r_div_pend;
    assign div_err  = (r_err == FDIV_ERR_DIV_ZERO);

endmodule

// File: tb/tb_fdiv_prog.sv
// Self-checking bench for fdiv_prog: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_fdiv_prog;

    localparam int W       = 4;
    localparam int DIV_RST = 5;
    localparam int EW      = W + 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         c_up = 1'b0;
    logic         div_ld = 1'b0;
    logic [W-1:0] div_val = '0;
    logic         fdclk;
    logic [W-1:0] cnt;
    logic         div_pend;
    logic         div_err;

    fdiv_prog #(
        .W(W),
        .DIV_RST(DIV_RST)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .c_up    (c_up),
        .div_ld  (div_ld),
        .div_val (div_val),
        .fdclk   (fdclk),
        .cnt     (cnt),
        .div_pend(div_pend),
        .div_err (div_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    // Entry layout: {cnt, fdclk, div_pend, div_err}
    logic [EW-1:0] exp_q[$];
    int m_cnt = 0, m_act = DIV_RST, m_nxt = DIV_RST;
    bit m_pend = 0, m_err = 0, m_fd = 0;

    always @(posedge clk) begin
        int  old_cnt, old_act, vv;
        bit  xfer;
        old_cnt = m_cnt;
        old_act = m_act;
        vv      = int'(div_val);
        if (rst) begin
            m_cnt = 0; m_act = DIV_RST; m_nxt = DIV_RST; m_pend = 0; m_err = 0; m_fd = 0;
        end else begin
            m_err = div_ld && (vv == 0);
            xfer  = m_pend && (clr || (c_up && old_cnt == old_act - 1));
            if (clr) m_cnt = 0;
            else if (c_up) m_cnt = (old_cnt == old_act - 1) ? 0 : old_cnt + 1;
            if (xfer) m_act = m_nxt;
            if (div_ld && vv != 0) begin
                m_nxt = vv; m_pend = 1;
            end else if (xfer) begin
                m_pend = 0;
            end
            if (clr) m_fd = 0;
            else if (old_act == 1) m_fd = 1;
            else if (c_up && old_cnt == 0) m_fd = 1;
            else if (c_up && old_cnt == old_act / 2) m_fd = 0;
        end
`ifdef FDIV_PROG_DUTY50_EN
        exp_q.push_back({W'(m_cnt), m_fd, m_pend, m_err});
`else
        exp_q.push_back({W'(m_cnt), (m_cnt == 0), m_pend, m_err});
`endif
    end

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_cnt",      int'(cnt),      int'(e[EW-1:3]));
            chk("sb_fdclk",    int'(fdclk),    int'(e[2]));
            chk("sb_div_pend", int'(div_pend), int'(e[1]));
            chk("sb_div_err",  int'(div_err),  int'(e[0]));
            total++;
            if (int'(cnt) >= m_act && m_act > 0) begin
                bad++;
                $display("FAIL range: cnt %0d not below divisor %0d", cnt, m_act);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; clr = 1'b0; c_up = 1'b0; div_ld = 1'b0; div_val = '0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic load(input int v);
        div_ld = 1'b1; div_val = W'(v);
        tick();
        div_ld = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seq5[5] = '{1, 2, 3, 4, 0};
        do_reset();
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_pend", int'(div_pend), 0);
        chk("rst_err", int'(div_err), 0);
`ifdef FDIV_PROG_DUTY50_EN
        chk("rst_fdclk", int'(fdclk), 0);
`else
        chk("rst_fdclk", int'(fdclk), 1);
`endif

        // Divide-by-5 sequence
        c_up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("seq5_cnt", int'(cnt), seq5[i]);
        end

        // Load 3 at cnt=1: pending until the 4->0 wrap, then period 3
        tick();
        load(3);
        chk("ld3_pend", int'(div_pend), 1);
        chk("ld3_cnt", int'(cnt), 2);
        tick(2);
        chk("ld3_pre_wrap", int'(cnt), 4);
        chk("ld3_pend_hold", int'(div_pend), 1);
        tick();
        chk("ld3_wrap_cnt", int'(cnt), 0);
        chk("ld3_pend_fall", int'(div_pend), 0);
        tick(2);
        chk("per3_top", int'(cnt), 2);
        tick();
        chk("per3_wrap", int'(cnt), 0);

        // Zero divisor rejected
        load(0);
        chk("zero_err", int'(div_err), 1);
        chk("zero_pend", int'(div_pend), 0);
        tick();
        chk("zero_err_pulse", int'(div_err), 0);

        // Clear with pending divisor 7 applies it at once
        do_reset();
        c_up = 1'b1;
        tick();
        load(7);
        tick();
        chk("clr_pre_cnt", int'(cnt), 3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_cnt", int'(cnt), 0);
        chk("clr_pend", int'(div_pend), 0);
        tick(6);
        chk("per7_top", int'(cnt), 6);
        tick();
        chk("per7_wrap", int'(cnt), 0);

        // Hold with c_up=0, then reset mid-count
        tick(2);
        c_up = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_cnt", int'(cnt), 2);
        end
        c_up = 1'b1;
        tick();
        chk("resume_cnt", int'(cnt), 3);
        do_reset();
        chk("midrst_cnt", int'(cnt), 0);
        c_up = 1'b1;
        tick(4);
        chk("midrst_per5_top", int'(cnt), 4);
        tick();
        chk("midrst_per5_wrap", int'(cnt), 0);

        // Load coinciding with transfer, and repeated loads while pending
        load(2);
        load(6);
        tick(2);
        chk("last_wins_pend", int'(div_pend), 1);
        div_ld = 1'b1; div_val = W'(3);
        tick();
        div_ld = 1'b0;
        chk("xfer_ld_cnt", int'(cnt), 0);
        chk("xfer_ld_pend", int'(div_pend), 1);
        tick(5);
        chk("per6_top", int'(cnt), 5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 149) == 0);
            clr     = ($urandom_range(0, 39) == 0);
            c_up    = ($urandom_range(0, 3) != 0);
            div_ld  = ($urandom_range(0, 7) == 0);
            div_val = W'($urandom_range(0, (1 << W) - 1));
            tick();
        end
        rst = 1'b0; clr = 1'b0; c_up = 1'b0; div_ld = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fdiv_prog.md
FDIV_PROG -- requirements
Module: fdiv_prog

Interface
REQ-001 Parameter W, default 4, width of counter and divisor (W >= 2).
REQ-002 Parameter DIV_RST, default 5, divisor value loaded at reset (1 <= DIV_RST <= 2^W-1).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 clr  in  1  synchronous counter clear; highest priority after rst.
REQ-006 c_up  in  1  count enable; counter holds when low.
REQ-007 div_ld  in  1  request to load new divisor from div_val.
REQ-008 div_val  in  W  requested divisor N.
REQ-009 fdclk  out  1  divided clock/tick output.
REQ-010 cnt  out  W  current counter value.
REQ-011 div_pend  out  1  new divisor accepted, not yet active.
REQ-012 div_err  out  1  one-cycle pulse: div_ld with div_val==0 rejected.

Function
REQ-013 Active divisor register div_act; counter runs 0,1,...,div_act-1, wraps to 0; one step per cycle with c_up=1.
REQ-014 fdclk (pulse mode) = combinational decode of cnt==0, high exactly one of every div_act enabled cycles.
REQ-015 div_act==1: cnt stays 0, fdclk constantly 1.
REQ-016 div_ld with div_val!=0: div_val stored in shadow div_nxt, div_pend=1 next cycle; div_act unchanged.
REQ-017 Shadow transfer: in cycle where cnt==div_act-1 and c_up=1, cnt->0, div_act<=div_nxt, div_pend<=0.
REQ-018 clr=1: cnt<=0; if div_pend=1, div_act<=div_nxt and div_pend<=0 in same cycle; c_up ignored.
REQ-019 div_ld coinciding with transfer cycle: transfer uses old div_nxt; new value captured, div_pend stays 1.
REQ-020 Repeated div_ld while pending: last value wins.
REQ-021 div_ld with div_val==0: shadow and div_pend unchanged, div_err=1 for one cycle.
REQ-022 c_up=0: cnt, fdclk, div_act frozen; div_ld still captured.
REQ-023 cnt never exceeds div_act-1; no out-of-range state reachable.

Reset
REQ-024 rst=1 at clock edge: cnt=0, div_act=div_nxt=DIV_RST, div_pend=0, div_err=0; fdclk=1 in pulse mode, 0 in duty mode.
REQ-025 rst overrides clr, c_up, div_ld in same cycle; rst mid-count aborts count, pending divisor discarded.

Configuration
REQ-026 Macro FDIV_PROG_DUTY50_EN.
REQ-027 Defined: fdclk registered toggle output: toggles when cnt==0 and when cnt==div_act>>1 (c_up=1), giving period 2*div_act... no -- fdclk period div_act cycles, high floor(div_act/2) cycles; div_act==1 gives fdclk=clk-rate toggle disabled, fdclk held 1.
REQ-028 Not defined: pulse mode per REQ-014 only; no extra flop.

Structure
REQ-029 Package fdiv_pkg: default W, DIV_RST, divisor-zero error code constant.
REQ-030 One sub-module fdiv_cnt: W-bit counter with sync clr, enable, terminal-count output; top holds divisor/shadow logic and output decode.

Verification
REQ-031 W=4, DIV_RST=5, c_up=1 after reset -> cnt 0,1,2,3,4,0; fdclk high at cnt 0, period 5 cycles.
REQ-032 div_ld div_val=3 at cnt=1 -> div_pend=1 until cnt=4->0 wrap, then period 3; div_pend falls same edge.
REQ-033 div_ld div_val=0 -> div_err one-cycle pulse, period stays 5, div_pend unchanged.
REQ-034 clr at cnt=3 with div_pend=1 (div_nxt=7) -> cnt=0 next cycle, period 7 immediately.
REQ-035 c_up=0 for 4 cycles at cnt=2 -> cnt held 2, fdclk steady; rst asserted mid-count -> cnt=0, div_act=5.
REQ-036 FDIV_PROG_DUTY50_EN, div_act=6 -> fdclk 3 high / 3 low; div_act=5 -> 2 high / 3 low.
